// File: rtl/id_stage_hs_pkg.sv
// Shared decode definitions for the ID stage: op widths, NO_RD/NO_WR codes,
// flag bit indices and the RV32I decoder used by id_stage_hs.
package id_stage_hs_pkg;

   localparam int unsigned ALU_OP_W = 4;
   localparam int unsigned MEM_RD_W = 3;
   localparam int unsigned MEM_WR_W = 2;
   localparam int unsigned BR_OP_W  = 3;
   localparam int unsigned FLAGS_W  = 7;

   // out_flags = {br, jal, jalr, sel_imm, op1_sel_pc, op1_sel_zero, op2_sel_4}
   localparam int unsigned FLAG_BR       = 6;
   localparam int unsigned FLAG_JAL      = 5;
   localparam int unsigned FLAG_JALR     = 4;
   localparam int unsigned FLAG_SEL_IMM  = 3;
   localparam int unsigned FLAG_OP1_PC   = 2;
   localparam int unsigned FLAG_OP1_ZERO = 1;
   localparam int unsigned FLAG_OP2_4    = 0;

   typedef enum logic [ALU_OP_W-1:0] {
      AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
   } alu_op_e;

   typedef enum logic [MEM_RD_W-1:0] {
      MemNoRd = 3'd0, MemLb = 3'd1, MemLh = 3'd2, MemLw = 3'd3, MemLbu = 3'd4, MemLhu = 3'd5
   } mem_rd_e;

   typedef enum logic [MEM_WR_W-1:0] {
      MemNoWr = 2'd0, MemSb = 2'd1, MemSh = 2'd2, MemSw = 2'd3
   } mem_wr_e;

   localparam logic [MEM_RD_W-1:0] NO_RD = MemNoRd;
   localparam logic [MEM_WR_W-1:0] NO_WR = MemNoWr;

   localparam logic [6:0] OpcOp     = 7'b0110011;
   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcJal    = 7'b1101111;
   localparam logic [6:0] OpcJalr   = 7'b1100111;
   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;

   typedef struct packed {
      logic [4:0]          rd;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic                rs1_rd;
      logic                rs2_rd;
      logic                reg_wen;
      logic                ill;
      logic [ALU_OP_W-1:0] alu_op;
      logic [MEM_RD_W-1:0] mem_rd_op;
      logic [MEM_WR_W-1:0] mem_wr_op;
      logic [BR_OP_W-1:0]  branch_op;
      logic [FLAGS_W-1:0]  flags;
      logic [31:0]         imm;
   } dec_t;

   function automatic logic [ALU_OP_W-1:0] alu_from_f3(input logic [2:0] f3);
      logic [ALU_OP_W-1:0] op;
      case (f3)
         3'd0:    op = AluAdd;
         3'd1:    op = AluSll;
         3'd2:    op = AluSlt;
         3'd3:    op = AluSltu;
         3'd4:    op = AluXor;
         3'd5:    op = AluSrl;
         3'd6:    op = AluOr;
         default: op = AluAnd;
      endcase
      return op;
   endfunction

   function automatic dec_t decode(input logic [31:0] i);
      dec_t       d;
      logic [2:0] f3;
      logic [6:0] f7;
      d       = '0;
      f3      = i[14:12];
      f7      = i[31:25];
      d.rd    = i[11:7];
      d.rs1   = i[19:15];
      d.rs2   = i[24:20];
      case (i[6:0])
         OpcOp: begin
            d.rs1_rd  = 1'b1;
            d.rs2_rd  = 1'b1;
            d.reg_wen = 1'b1;
            if (f7 == 7'h00) d.alu_op = alu_from_f3(f3);
            else if (f7 == 7'h20 && f3 == 3'd0) d.alu_op = AluSub;
            else if (f7 == 7'h20 && f3 == 3'd5) d.alu_op = AluSra;
            else d.ill = 1'b1;
         end
         OpcOpImm: begin
            d.rs1_rd                = 1'b1;
            d.reg_wen               = 1'b1;
            d.flags[FLAG_SEL_IMM]   = 1'b1;
            d.imm                   = {{20{i[31]}}, i[31:20]};
            d.alu_op                = alu_from_f3(f3);
            if (f3 == 3'd1 && f7 != 7'h00) d.ill = 1'b1;
            if (f3 == 3'd5) begin
               if (f7 == 7'h20) d.alu_op = AluSra;
               else if (f7 != 7'h00) d.ill = 1'b1;
            end
         end
         OpcLoad: begin
            d.rs1_rd              = 1'b1;
            d.reg_wen             = 1'b1;
            d.flags[FLAG_SEL_IMM] = 1'b1;
            d.imm                 = {{20{i[31]}}, i[31:20]};
            case (f3)
               3'd0:    d.mem_rd_op = MemLb;
               3'd1:    d.mem_rd_op = MemLh;
               3'd2:    d.mem_rd_op = MemLw;
               3'd4:    d.mem_rd_op = MemLbu;
               3'd5:    d.mem_rd_op = MemLhu;
               default: d.ill = 1'b1;
            endcase
         end
         OpcStore: begin
            d.rs1_rd              = 1'b1;
            d.rs2_rd              = 1'b1;
            d.flags[FLAG_SEL_IMM] = 1'b1;
            d.imm                 = {{20{i[31]}}, i[31:25], i[11:7]};
            case (f3)
               3'd0:    d.mem_wr_op = MemSb;
               3'd1:    d.mem_wr_op = MemSh;
               3'd2:    d.mem_wr_op = MemSw;
               default: d.ill = 1'b1;
            endcase
         end
         OpcBranch: begin
            d.rs1_rd         = 1'b1;
            d.rs2_rd         = 1'b1;
            d.flags[FLAG_BR] = 1'b1;
            d.branch_op      = f3;
            d.alu_op         = AluSub;
            d.imm            = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            if (f3 == 3'd2 || f3 == 3'd3) d.ill = 1'b1;
         end
         OpcJal: begin
            d.reg_wen             = 1'b1;
            d.flags[FLAG_JAL]     = 1'b1;
            d.flags[FLAG_OP1_PC]  = 1'b1;
            d.flags[FLAG_OP2_4]   = 1'b1;
            d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         end
         OpcJalr: begin
            d.rs1_rd              = 1'b1;
            d.reg_wen             = 1'b1;
            d.flags[FLAG_JALR]    = 1'b1;
            d.flags[FLAG_OP1_PC]  = 1'b1;
            d.flags[FLAG_OP2_4]   = 1'b1;
            d.imm                 = {{20{i[31]}}, i[31:20]};
            if (f3 != 3'd0) d.ill = 1'b1;
         end
         OpcLui: begin
            d.reg_wen              = 1'b1;
            d.flags[FLAG_SEL_IMM]  = 1'b1;
            d.flags[FLAG_OP1_ZERO] = 1'b1;
            d.imm                  = {i[31:12], 12'b0};
         end
         OpcAuipc: begin
            d.reg_wen             = 1'b1;
            d.flags[FLAG_SEL_IMM] = 1'b1;
            d.flags[FLAG_OP1_PC]  = 1'b1;
            d.imm                 = {i[31:12], 12'b0};
         end
         default: d.ill = 1'b1;
      endcase
      // Illegal instructions must have no architectural side effects downstream
      if (d.ill) begin
         d.reg_wen         = 1'b0;
         d.rs1_rd          = 1'b0;
         d.rs2_rd          = 1'b0;
         d.mem_rd_op       = NO_RD;
         d.mem_wr_op       = NO_WR;
         d.flags[FLAG_BR]  = 1'b0;
         d.flags[FLAG_JAL] = 1'b0;
         d.flags[FLAG_JALR] = 1'b0;
      end
      if (d.rd == 5'd0) d.reg_wen = 1'b0;
      return d;
   endfunction

endpackage

// File: rtl/id_stage_hs_if.sv
// Handshake/bus bundle between IF/ID, the ID stage, EX and writeback.
// slave = ID stage view, master = surrounding pipeline view.
interface id_stage_hs_if #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned PC_W       = 32,
   parameter int unsigned RF_AW      = 5,
   parameter int unsigned FWD_STAGES = 2
);
   import id_stage_hs_pkg::*;
   localparam int unsigned FSW = $clog2(FWD_STAGES + 1);

   logic                        flush;
   logic                        in_valid;
   logic                        in_ready;
   logic [PC_W-1:0]             in_pc;
   logic [31:0]                 in_instr;
   logic [FWD_STAGES-1:0]       fwd_wen;
   logic [FWD_STAGES*RF_AW-1:0] fwd_waddr;
   logic [FWD_STAGES-1:0]       fwd_is_load;
   logic                        wb_wen;
   logic [RF_AW-1:0]            wb_waddr;
   logic [XLEN-1:0]             wb_wdata;
   logic                        out_valid;
   logic                        out_ready;
   logic [PC_W-1:0]             out_pc;
   logic                        out_reg_wen;
   logic [RF_AW-1:0]            out_reg_waddr;
   logic [XLEN-1:0]             out_rs1_data;
   logic [XLEN-1:0]             out_rs2_data;
   logic [XLEN-1:0]             out_imm;
   logic [ALU_OP_W-1:0]         out_alu_op;
   logic [MEM_RD_W-1:0]         out_mem_rd_op;
   logic [MEM_WR_W-1:0]         out_mem_wr_op;
   logic [BR_OP_W-1:0]          out_branch_op;
   logic [FLAGS_W-1:0]          out_flags;
   logic [FSW-1:0]              out_op1_fwd_sel;
   logic [FSW-1:0]              out_op2_fwd_sel;
   logic                        out_ill_instr;
   logic                        load_stall;
   logic [31:0]                 stall_cnt;

   modport slave (
      input  flush, in_valid, in_pc, in_instr, fwd_wen, fwd_waddr, fwd_is_load,
             wb_wen, wb_waddr, wb_wdata, out_ready,
      output in_ready, out_valid, out_pc, out_reg_wen, out_reg_waddr, out_rs1_data,
             out_rs2_data, out_imm, out_alu_op, out_mem_rd_op, out_mem_wr_op, out_branch_op,
             out_flags, out_op1_fwd_sel, out_op2_fwd_sel, out_ill_instr, load_stall, stall_cnt
   );

   modport master (
      output flush, in_valid, in_pc, in_instr, fwd_wen, fwd_waddr, fwd_is_load,
             wb_wen, wb_waddr, wb_wdata, out_ready,
      input  in_ready, out_valid, out_pc, out_reg_wen, out_reg_waddr, out_rs1_data,
             out_rs2_data, out_imm, out_alu_op, out_mem_rd_op, out_mem_wr_op, out_branch_op,
             out_flags, out_op1_fwd_sel, out_op2_fwd_sel, out_ill_instr, load_stall, stall_cnt
   );
endinterface

// File: rtl/id_stage_hs_fwd_select.sv
// Priority forwarding match of one source register over the downstream write
// stages. Stage 0 is the youngest and wins. Also flags a load result that is
// still too young to forward.
module id_stage_hs_fwd_select #(
   parameter int unsigned RF_AW      = 5,
   parameter int unsigned FWD_STAGES = 2,
   parameter int unsigned LOAD_LAT   = 1
) (
   input  logic [RF_AW-1:0]                     rs,
   input  logic                                 rs_rd,
   input  logic [FWD_STAGES-1:0]                fwd_wen,
   input  logic [FWD_STAGES*RF_AW-1:0]          fwd_waddr,
   input  logic [FWD_STAGES-1:0]                fwd_is_load,
   output logic [$clog2(FWD_STAGES+1)-1:0]      sel,
   output logic                                 load_hazard
);
   localparam int unsigned FSW = $clog2(FWD_STAGES + 1);

   // Scan oldest to youngest so the youngest match overwrites the result
   always_comb begin
      sel         = '0;
      load_hazard = 1'b0;
      for (int i = int'(FWD_STAGES) - 1; i >= 0; i--) begin
         if (rs_rd && rs != '0 && fwd_wen[i] && fwd_waddr[i*RF_AW +: RF_AW] == rs) begin
            sel         = FSW'(i + 1);
            load_hazard = fwd_is_load[i] && (i < int'(LOAD_LAT));
         end
      end
   end
endmodule

// File: rtl/id_stage_hs.sv
// Instruction-decode stage with valid/ready handshake, N-deep forwarding
// select, load-use interlock and a saturating stall counter.
// Optional feature macro: ID_RF_BYPASS_EN (regfile write-through on read).
module id_stage_hs
   import id_stage_hs_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned PC_W       = 32,
   parameter int unsigned RF_AW      = 5,
   parameter int unsigned FWD_STAGES = 2,
   parameter int unsigned LOAD_LAT   = 1
) (
   input logic          clk,
   input logic          rst,
   id_stage_hs_if.slave bus
);
   localparam int unsigned FSW = $clog2(FWD_STAGES + 1);

   typedef struct packed {
      logic                valid;
      logic [PC_W-1:0]     pc;
      logic                reg_wen;
      logic [RF_AW-1:0]    reg_waddr;
      logic [XLEN-1:0]     rs1_data;
      logic [XLEN-1:0]     rs2_data;
      logic [XLEN-1:0]     imm;
      logic [ALU_OP_W-1:0] alu_op;
      logic [MEM_RD_W-1:0] mem_rd_op;
      logic [MEM_WR_W-1:0] mem_wr_op;
      logic [BR_OP_W-1:0]  branch_op;
      logic [FLAGS_W-1:0]  flags;
      logic [FSW-1:0]      op1_sel;
      logic [FSW-1:0]      op2_sel;
      logic                ill;
   } out_t;

   dec_t             dec;
   logic [RF_AW-1:0] rs1_a, rs2_a;
   logic [XLEN-1:0]  rs1_data, rs2_data;
   logic [FSW-1:0]   op1_sel, op2_sel;
   logic             haz1, haz2;
   logic             load_stall_c, adv, issue;
   logic [XLEN-1:0]  rf_q [2**RF_AW];
   out_t             out_q, out_d;
   logic [31:0]      stall_cnt_q, stall_cnt_d;

   assign dec   = decode(bus.in_instr);
   assign rs1_a = RF_AW'(dec.rs1);
   assign rs2_a = RF_AW'(dec.rs2);

   // Regfile write port; entry 0 is never written and always reads as zero
   always_ff @(posedge clk) begin
      if (bus.wb_wen && bus.wb_waddr != '0) rf_q[bus.wb_waddr] <= bus.wb_wdata;
   end

   // Regfile read ports, optionally returning same-cycle writeback data
   always_comb begin
      rs1_data = (rs1_a == '0) ? '0 : rf_q[rs1_a];
      rs2_data = (rs2_a == '0) ? '0 : rf_q[rs2_a];
`ifdef ID_RF_BYPASS_EN
      if (bus.wb_wen && bus.wb_waddr == rs1_a && rs1_a != '0) rs1_data = bus.wb_wdata;
      if (bus.wb_wen && bus.wb_waddr == rs2_a && rs2_a != '0) rs2_data = bus.wb_wdata;
`endif
   end

   id_stage_hs_fwd_select #(
      .RF_AW      (RF_AW),
      .FWD_STAGES (FWD_STAGES),
      .LOAD_LAT   (LOAD_LAT)
   ) u_fwd_rs1 (
      .rs          (rs1_a),
      .rs_rd       (dec.rs1_rd),
      .fwd_wen     (bus.fwd_wen),
      .fwd_waddr   (bus.fwd_waddr),
      .fwd_is_load (bus.fwd_is_load),
      .sel         (op1_sel),
      .load_hazard (haz1)
   );

   id_stage_hs_fwd_select #(
      .RF_AW      (RF_AW),
      .FWD_STAGES (FWD_STAGES),
      .LOAD_LAT   (LOAD_LAT)
   ) u_fwd_rs2 (
      .rs          (rs2_a),
      .rs_rd       (dec.rs2_rd),
      .fwd_wen     (bus.fwd_wen),
      .fwd_waddr   (bus.fwd_waddr),
      .fwd_is_load (bus.fwd_is_load),
      .sel         (op2_sel),
      .load_hazard (haz2)
   );

   // Flush outranks the interlock: a flushed instruction never stalls
   assign load_stall_c = bus.in_valid & ~bus.flush & (haz1 | haz2);
   assign adv          = ~out_q.valid | bus.out_ready;
   assign issue        = bus.in_valid & ~bus.flush & ~load_stall_c;

   // Next output payload: load on issue, bubble otherwise, hold while frozen
   always_comb begin
      out_d = out_q;
      if (adv) begin
         out_d.valid = issue;
         if (issue) begin
            out_d.pc        = bus.in_pc;
            out_d.reg_wen   = dec.reg_wen;
            out_d.reg_waddr = RF_AW'(dec.rd);
            out_d.rs1_data  = rs1_data;
            out_d.rs2_data  = rs2_data;
            out_d.imm       = XLEN'(dec.imm);
            out_d.alu_op    = dec.alu_op;
            out_d.mem_rd_op = dec.mem_rd_op;
            out_d.mem_wr_op = dec.mem_wr_op;
            out_d.branch_op = dec.branch_op;
            out_d.flags     = dec.flags;
            out_d.op1_sel   = op1_sel;
            out_d.op2_sel   = op2_sel;
            out_d.ill       = dec.ill;
         end else begin
            out_d.reg_wen   = 1'b0;
            out_d.mem_rd_op = NO_RD;
            out_d.mem_wr_op = NO_WR;
            out_d.branch_op = '0;
            out_d.flags     = '0;
            out_d.op1_sel   = '0;
            out_d.op2_sel   = '0;
            out_d.ill       = 1'b0;
         end
      end
   end

   // Saturating count of cycles lost to the load-use interlock
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (load_stall_c && adv && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   // Output and counter state with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         out_q       <= out_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.in_ready        = bus.flush | (adv & ~load_stall_c);
   assign bus.load_stall      = load_stall_c;
   assign bus.stall_cnt       = stall_cnt_q;
   assign bus.out_valid       = out_q.valid;
   assign bus.out_pc          = out_q.pc;
   assign bus.out_reg_wen     = out_q.reg_wen;
   assign bus.out_reg_waddr   = out_q.reg_waddr;
   assign bus.out_rs1_data    = out_q.rs1_data;
   assign bus.out_rs2_data    = out_q.rs2_data;
   assign bus.out_imm         = out_q.imm;
   assign bus.out_alu_op      = out_q.alu_op;
   assign bus.out_mem_rd_op   = out_q.mem_rd_op;
   assign bus.out_mem_wr_op   = out_q.mem_wr_op;
   assign bus.out_branch_op   = out_q.branch_op;
   assign bus.out_flags       = out_q.flags;
   assign bus.out_op1_fwd_sel = out_q.op1_sel;
   assign bus.out_op2_fwd_sel = out_q.op2_sel;
   assign bus.out_ill_instr   = out_q.ill;
endmodule

// File: tb/tb_id_stage_hs.sv
// Directed self-checking bench for id_stage_hs (default parameters).
module tb_id_stage_hs;
   import id_stage_hs_pkg::*;

   localparam logic [31:0] ADD_X3_X1_X2 = 32'h002081B3;
   localparam logic [31:0] ADD_X3_X0_X2 = 32'h002001B3;
   localparam logic [31:0] ADD_X6_X5_X2 = 32'h00228333;
   localparam logic [31:0] ADD_X8_X7_X0 = 32'h00038433;
   localparam logic [31:0] LW_X5_4_X1   = 32'h0040A283;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;

   id_stage_hs_if #(.XLEN(32), .PC_W(32), .RF_AW(5), .FWD_STAGES(2)) bus ();

   id_stage_hs #(
      .XLEN       (32),
      .PC_W       (32),
      .RF_AW      (5),
      .FWD_STAGES (2),
      .LOAD_LAT   (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_fwd(input logic [1:0] wen, input logic [4:0] a1, input logic [4:0] a0,
                          input logic [1:0] ld);
      bus.fwd_wen     = wen;
      bus.fwd_waddr   = {a1, a0};
      bus.fwd_is_load = ld;
   endtask

   task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
      bus.wb_wen   = 1'b1;
      bus.wb_waddr = a;
      bus.wb_wdata = d;
      step();
      bus.wb_wen   = 1'b0;
   endtask

   initial begin
      rst          = 1'b0;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_pc    = 32'h0;
      bus.in_instr = 32'h0;
      bus.wb_wen   = 1'b0;
      bus.wb_waddr = 5'd0;
      bus.wb_wdata = 32'h0;
      bus.out_ready = 1'b1;
      set_fwd(2'b00, 5'd0, 5'd0, 2'b00);
      repeat (2) step();

      // Reset state
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_reg_wen", 64'(bus.out_reg_wen), 64'd0);
      check("rst_mem_rd", 64'(bus.out_mem_rd_op), 64'(MemNoRd));
      check("rst_mem_wr", 64'(bus.out_mem_wr_op), 64'(MemNoWr));
      check("rst_flags", 64'(bus.out_flags), 64'd0);
      check("rst_ill", 64'(bus.out_ill_instr), 64'd0);
      check("rst_sel1", 64'(bus.out_op1_fwd_sel), 64'd0);
      check("rst_rs1_data", 64'(bus.out_rs1_data), 64'd0);
      check("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);

      rst = 1'b1;
      wb_write(5'd1, 32'h0000_0011);
      wb_write(5'd2, 32'h0000_0022);
      wb_write(5'd5, 32'h0000_0055);
      wb_write(5'd7, 32'h0000_1234);

      // Plain add from the regfile
      bus.in_valid = 1'b1;
      bus.in_pc    = 32'h0000_0100;
      bus.in_instr = ADD_X3_X1_X2;
      #1;
      check("add_in_ready", 64'(bus.in_ready), 64'd1);
      check("add_no_stall", 64'(bus.load_stall), 64'd0);
      step();
      check("add_valid", 64'(bus.out_valid), 64'd1);
      check("add_pc", 64'(bus.out_pc), 64'h100);
      check("add_waddr", 64'(bus.out_reg_waddr), 64'd3);
      check("add_wen", 64'(bus.out_reg_wen), 64'd1);
      check("add_alu", 64'(bus.out_alu_op), 64'(AluAdd));
      check("add_rs1", 64'(bus.out_rs1_data), 64'h11);
      check("add_rs2", 64'(bus.out_rs2_data), 64'h22);
      check("add_sel1", 64'(bus.out_op1_fwd_sel), 64'd0);
      check("add_sel2", 64'(bus.out_op2_fwd_sel), 64'd0);

      // Both stages write x1: youngest wins
      set_fwd(2'b11, 5'd1, 5'd1, 2'b00);
      step();
      check("fwd_young_sel1", 64'(bus.out_op1_fwd_sel), 64'd1);
      check("fwd_young_sel2", 64'(bus.out_op2_fwd_sel), 64'd0);

      // x0 source never forwards; x2 matches stage 1
      bus.in_instr = ADD_X3_X0_X2;
      set_fwd(2'b11, 5'd2, 5'd0, 2'b00);
      step();
      check("fwd_x0_sel1", 64'(bus.out_op1_fwd_sel), 64'd0);
      check("fwd_x0_sel2", 64'(bus.out_op2_fwd_sel), 64'd2);

      // Load-use: lw x5 in stage 0, add x6,x5,x2 must stall one cycle
      bus.in_instr = ADD_X6_X5_X2;
      set_fwd(2'b01, 5'd0, 5'd5, 2'b01);
      #1;
      check("lu_stall", 64'(bus.load_stall), 64'd1);
      check("lu_in_ready", 64'(bus.in_ready), 64'd0);
      step();
      check("lu_bubble", 64'(bus.out_valid), 64'd0);
      check("lu_bubble_wen", 64'(bus.out_reg_wen), 64'd0);
      check("lu_cnt", 64'(bus.stall_cnt), 64'd1);
      set_fwd(2'b10, 5'd5, 5'd0, 2'b10);
      #1;
      check("lu_release", 64'(bus.load_stall), 64'd0);
      step();
      check("lu_issue_valid", 64'(bus.out_valid), 64'd1);
      check("lu_issue_sel1", 64'(bus.out_op1_fwd_sel), 64'd2);
      check("lu_issue_waddr", 64'(bus.out_reg_waddr), 64'd6);
      check("lu_issue_cnt", 64'(bus.stall_cnt), 64'd1);

      // Backpressure with a load hazard pending: everything freezes
      bus.out_ready = 1'b0;
      bus.in_instr  = ADD_X3_X1_X2;
      set_fwd(2'b01, 5'd0, 5'd1, 2'b01);
      #1;
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_stall", 64'(bus.load_stall), 64'd1);
      for (int c = 0; c < 3; c++) begin
         step();
         check("bp_valid", 64'(bus.out_valid), 64'd1);
         check("bp_waddr", 64'(bus.out_reg_waddr), 64'd6);
         check("bp_sel1", 64'(bus.out_op1_fwd_sel), 64'd2);
         check("bp_cnt", 64'(bus.stall_cnt), 64'd1);
      end
      bus.out_ready = 1'b1;
      set_fwd(2'b00, 5'd0, 5'd0, 2'b00);
      #1;
      check("bp_release_ready", 64'(bus.in_ready), 64'd1);
      step();
      check("bp_next_waddr", 64'(bus.out_reg_waddr), 64'd3);
      check("bp_next_sel1", 64'(bus.out_op1_fwd_sel), 64'd0);

      // Flush beats the interlock: bubble and no stall count
      bus.flush    = 1'b1;
      bus.in_instr = ADD_X6_X5_X2;
      set_fwd(2'b01, 5'd0, 5'd5, 2'b01);
      #1;
      check("fl_no_stall", 64'(bus.load_stall), 64'd0);
      check("fl_in_ready", 64'(bus.in_ready), 64'd1);
      step();
      check("fl_valid", 64'(bus.out_valid), 64'd0);
      check("fl_cnt", 64'(bus.stall_cnt), 64'd1);
      bus.flush = 1'b0;
      set_fwd(2'b00, 5'd0, 5'd0, 2'b00);

      // Writeback to x7 in the same cycle as a read of x7
      bus.in_instr = ADD_X8_X7_X0;
      bus.wb_wen   = 1'b1;
      bus.wb_waddr = 5'd7;
      bus.wb_wdata = 32'hDEAD_BEEF;
      step();
      bus.wb_wen = 1'b0;
`ifdef ID_RF_BYPASS_EN
      check("rf_same_cycle", 64'(bus.out_rs1_data), 64'hDEAD_BEEF);
`else
      check("rf_same_cycle", 64'(bus.out_rs1_data), 64'h1234);
`endif
      check("rf_x0_read", 64'(bus.out_rs2_data), 64'd0);
      step();
      check("rf_after_wb", 64'(bus.out_rs1_data), 64'hDEAD_BEEF);

      // Illegal instruction
      bus.in_instr = 32'hFFFF_FFFF;
      step();
      check("ill_valid", 64'(bus.out_valid), 64'd1);
      check("ill_flag", 64'(bus.out_ill_instr), 64'd1);
      check("ill_wen", 64'(bus.out_reg_wen), 64'd0);
      check("ill_mem_rd", 64'(bus.out_mem_rd_op), 64'(MemNoRd));
      check("ill_flags", 64'(bus.out_flags), 64'd0);

      // Load word decode
      bus.in_instr = LW_X5_4_X1;
      step();
      check("lw_mem_rd", 64'(bus.out_mem_rd_op), 64'(MemLw));
      check("lw_imm", 64'(bus.out_imm), 64'd4);
      check("lw_flags", 64'(bus.out_flags), 64'h08);
      check("lw_wen", 64'(bus.out_reg_wen), 64'd1);
      check("lw_ill", 64'(bus.out_ill_instr), 64'd0);

      // Reset in the middle of a stall
      bus.in_instr = ADD_X6_X5_X2;
      set_fwd(2'b01, 5'd0, 5'd5, 2'b01);
      step();
      check("ms_cnt", 64'(bus.stall_cnt), 64'd2);
      rst = 1'b0;
      step();
      check("ms_rst_cnt", 64'(bus.stall_cnt), 64'd0);
      check("ms_rst_valid", 64'(bus.out_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
